// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcode encodings, opcode width and
// the two-state arbiter encoding.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU; results wrap modulo 2^WIDTH and undefined opcodes give zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] y_o,
    output logic             z_o
);

    // Operation select
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

    assign z_o = (y_o == '0);

endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin winner: first asserted request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic            valid_o,
    output logic [1:0]      win_o
);

    // Scan distances from the pointer so the nearest requester wins
    always_comb begin
        valid_o = 1'b0;
        win_o   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!valid_o && req_i[j] && (j == (int'(ptr_i) + k) % NREQ)) begin
                    valid_o = 1'b1;
                    win_o   = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one ALU between NREQ requesters.
// Optional ALU_ARB_STATS_EN adds per-requester saturating grant counters (gnt_count).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int NREQ  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  a_in,
    input  logic [NREQ*WIDTH-1:0]  b_in,
    input  logic [NREQ*OP_W-1:0]   op_in,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [WIDTH-1:0]       rsp_y,
    output logic                   rsp_z
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]     gnt_count
`endif
);

    arb_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       win_q, win_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_z_q, rsp_z_d;

    logic             pick_valid;
    logic [1:0]       pick_win;
    logic [WIDTH-1:0] alu_y;
    logic             alu_z;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y),
        .z_o  (alu_z)
    );

    // Next-state: IDLE latches the winner's operation, GRANT publishes the ALU result
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_z_d     = rsp_z_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_win;
                    a_d     = a_in[int'(pick_win)*WIDTH +: WIDTH];
                    b_d     = b_in[int'(pick_win)*WIDTH +: WIDTH];
                    op_d    = op_in[int'(pick_win)*OP_W +: OP_W];
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_win;
                    ptr_d   = (pick_win == 2'(NREQ-1)) ? 2'd0 : pick_win + 2'd1;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                rsp_y_d     = alu_y;
                rsp_z_d     = alu_z;
                rsp_id_d    = win_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            win_q       <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
            rsp_y_q     <= '0;
            rsp_z_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_z_q     <= rsp_z_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_z     = rsp_z_q;

`ifdef ALU_ARB_STATS_EN
    logic [NREQ-1:0][15:0] cnt_q;

    // Grant counters saturate so a long run never wraps to a misleadingly small count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_q[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign gnt_count = cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed corner cases plus randomized traffic
// against a behavioural round-robin/ALU reference model.
module tb_alu_share_arb;

    localparam int WIDTH = 7;
    localparam int NREQ  = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ*3-1:0]     op_in;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_z;
`ifdef ALU_ARB_STATS_EN
    logic [NREQ*16-1:0]    gnt_count;
`endif

    logic [WIDTH-1:0] a_v [NREQ];
    logic [WIDTH-1:0] b_v [NREQ];
    logic [2:0]       op_v[NREQ];

    int n_checks;
    int n_fail;
    int m_ptr;
    int m_cnt[NREQ];

    assign a_in  = {a_v[1], a_v[0]};
    assign b_in  = {b_v[1], b_v[0]};
    assign op_in = {op_v[1], op_v[0]};

    alu_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .op_in     (op_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_z     (rsp_z)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_count (gnt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int alu_ref(int a, int b, int op);
        case (op)
            0:       return (a + b) % 128;
            1:       return (a - b + 128) % 128;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One arbitration round from an IDLE edge: r is presented, r_after follows the grant
    task automatic op(input logic [1:0] r, input logic [1:0] r_after);
        int w;
        int y;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        req = r;
        @(negedge clk);
        check("gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
        check("no_rsp_in_gnt", 32'(rsp_valid), 32'd0);
        y = (w < 0) ? 0 : alu_ref(int'(a_v[w]), int'(b_v[w]), int'(op_v[w]));
        req = r_after;
        @(negedge clk);
        if (w >= 0) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(w));
            check("rsp_y", 32'(rsp_y), 32'(y));
            check("rsp_z", 32'(rsp_z), (y == 0) ? 32'd1 : 32'd0);
            check("gnt_low", 32'(gnt), 32'd0);
            m_ptr = (w + 1) % NREQ;
            m_cnt[w]++;
        end else begin
            check("no_rsp", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int o);
        a_v[i]  = 7'(a);
        b_v[i]  = 7'(b);
        op_v[i] = 3'(o);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ptr    = 0;
        m_cnt    = '{0, 0};
        rst      = 1'b1;
        req      = 2'b00;
        set_ops(0, 0, 0, 0);
        set_ops(1, 0, 0, 0);

        // Reset state
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_y", 32'(rsp_y), 32'd0);
        check("rst_z", 32'(rsp_z), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: 5 + 3
        set_ops(0, 5, 3, 0);
        op(2'b01, 2'b00);

        // Contention with both requesters held
        set_ops(0, 20, 7, 1);
        set_ops(1, 9, 12, 4);
        op(2'b11, 2'b11);
        op(2'b11, 2'b11);
        op(2'b11, 2'b11);
        op(2'b11, 2'b00);

        // Wrap and zero-flag corners
        set_ops(0, 127, 1, 0);
        op(2'b01, 2'b00);
        set_ops(0, 0, 1, 1);
        op(2'b01, 2'b00);
        set_ops(0, 55, 33, 6);
        op(2'b01, 2'b00);

        // Withdraw: req1 pulses between edges and is never seen
        req = 2'b10;
        #1;
        req = 2'b00;
        @(negedge clk);
        check("wd_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("wd_rsp", 32'(rsp_valid), 32'd0);

        // req1 raised only during GRANT is served at the next IDLE edge
        set_ops(0, 10, 10, 2);
        set_ops(1, 3, 4, 3);
        op(2'b01, 2'b10);
        op(2'b10, 2'b00);

        // Reset during GRANT drops the op and restarts the pointer
        set_ops(1, 1, 1, 0);
        req = 2'b10;
        @(negedge clk);
        check("mid_gnt", 32'(gnt), 32'd2);
        rst = 1'b1;
        req = 2'b00;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        m_ptr = 0;
        m_cnt = '{0, 0};
        @(negedge clk);
        check("mid_after_rsp", 32'(rsp_valid), 32'd0);
        op(2'b11, 2'b00);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_ops(i, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                        int'($urandom_range(0, 7)));
            end
            op(2'($urandom_range(0, 3)), 2'b00);
        end

`ifdef ALU_ARB_STATS_EN
        check("cnt0", 32'(gnt_count[15:0]), 32'(m_cnt[0]));
        check("cnt1", 32'(gnt_count[31:16]), 32'(m_cnt[1]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
